cpu: RTL and testbench

//  Multi-cycle RV32I-subset processor core. Sole master of the single shared memory port:

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_regfile.sv | 32 +++
 rtl/cpu.sv | 149 ++++++++++++++
 tb/tb_cpu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, function codes,
// FSM states and the ALU operation set with its evaluation function.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_t;

  function automatic logic [31:0] alu_eval(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
      ALU_PASS_B: return b;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero and ignores writes.
module cpu_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] regs [NREGS];

  // NOTE: this array is reset on purpose so an aborted instruction leaves no stale
  // value behind; it therefore maps to flops, not to a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/cpu.sv
// Multi-cycle RV32I-subset core (FETCH/EXEC/MEM/WB); sole master of a synchronous ROM
// port. Decode, immediate generation, ALU and sequencing are kept inline.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        we_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] inst;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] pc_plus4, next_pc, ea, alu_b, alu_result;
  alu_op_t     alu_op;
  logic        exec_wr, is_load;
  logic        rf_we;
  logic [31:0] rf_wdata;

  // The instruction arrives on data_i during EXEC only; later states decode the latched copy.
  assign inst   = (state == EXEC) ? data_i : ir;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  assign pc_plus4 = pc + 32'd4;
  assign ea       = (rs1_data + imm_i) & WORD_MASK;

  cpu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (rf_wdata)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rs2_data;
    exec_wr = 1'b0;
    is_load = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_OP: begin
        exec_wr = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD_SUB}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLT}:     alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
          {F7_BASE, F3_OR}:      alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     alu_op = ALU_AND;
          default:               exec_wr = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        alu_b   = imm_i;
        exec_wr = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    exec_wr = 1'b0;
        endcase
      end
      OPC_LUI: begin
        alu_op  = ALU_PASS_B;
        alu_b   = imm_u;
        exec_wr = 1'b1;
      end
      OPC_JAL: begin
        alu_op  = ALU_PASS_B;
        alu_b   = pc_plus4;
        exec_wr = 1'b1;
        next_pc = (pc + imm_j) & WORD_MASK;
      end
      OPC_BRANCH: begin
        if ((funct3 == F3_BEQ && rs1_data == rs2_data) ||
            (funct3 == F3_BNE && rs1_data != rs2_data))
          next_pc = (pc + imm_b) & WORD_MASK;
      end
      OPC_LOAD: is_load = (funct3 == F3_LW);
      default: ;
    endcase
  end

  assign alu_result = alu_eval(alu_op, rs1_data, alu_b);
  assign rf_we      = (state == EXEC && exec_wr) || (state == WB);
  assign rf_wdata   = (state == WB) ? data_i : alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          ir <= data_i;
          if (is_load) begin
            state <= MEM;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        MEM: state <= WB;
        WB: begin
          pc    <= pc_plus4;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign addr_o = (state == MEM) ? ea : pc;
  assign we_o   = 1'b0;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: a hand-assembled program in a synchronous ROM model, checked
// per instruction from a vector table, plus a reset-during-load sequence.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_i = '0;

  logic [31:0] rom [64];
  int          errors = 0;
  int          checks = 0;
  int          we_bad = 0;

  typedef struct {
    logic [31:0] pc;
    bit          is_load;
    logic [31:0] ea;
    logic [4:0]  rd;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[$];

  cpu dut (
    .clk    (clk),
    .reset  (reset),
    .we_o   (we_o),
    .addr_o (addr_o),
    .data_i (data_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_i <= (addr_o < 32'd256) ? rom[addr_o[7:2]] : 32'h0;

  always @(negedge clk) if (we_o !== 1'b0) we_bad++;

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                        logic [31:0] rd, logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3, logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic vec_t mk(logic [31:0] pc, bit is_load, logic [31:0] ea,
                              logic [4:0] rd, logic [31:0] val);
    vec_t v;
    v.pc = pc; v.is_load = is_load; v.ea = ea; v.rd = rd; v.val = val;
    return v;
  endfunction

  function automatic logic [31:0] reg_val(logic [4:0] idx);
    return dut.u_regfile.regs[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge inside FETCH; returns at the negedge inside the next FETCH.
  task automatic run_vec(input vec_t v);
    check($sformatf("fetch_addr@%0h", v.pc), addr_o, v.pc);
    @(negedge clk);
    check($sformatf("exec_addr@%0h", v.pc), addr_o, v.pc);
    if (v.is_load) begin
      @(negedge clk);
      check($sformatf("mem_addr@%0h", v.pc), addr_o, v.ea);
      @(negedge clk);
      check($sformatf("wb_addr@%0h", v.pc), addr_o, v.pc);
    end
    @(negedge clk);
    check($sformatf("x%0d@%0h", v.rd, v.pc), reg_val(v.rd), v.val);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]  = enc_i(5,     0, 0, 1,  7'b0010011);   // addi x1,x0,5
    rom[1]  = enc_i(-3,    0, 0, 2,  7'b0010011);   // addi x2,x0,-3
    rom[2]  = enc_r(0,     2, 1, 0, 3);             // add  x3,x1,x2
    rom[3]  = {20'h12345, 5'd4, 7'b0110111};        // lui  x4,0x12345
    rom[4]  = enc_i(7,     0, 0, 0,  7'b0010011);   // addi x0,x0,7
    rom[5]  = enc_i(84,    0, 2, 5,  7'b0000011);   // lw   x5,84(x0)
    rom[6]  = enc_i(86,    0, 2, 6,  7'b0000011);   // lw   x6,86(x0)
    rom[7]  = enc_r(7'h20, 1, 2, 0, 7);             // sub  x7,x2,x1
    rom[8]  = enc_r(0,     1, 2, 2, 8);             // slt  x8,x2,x1
    rom[9]  = enc_i(-1,    1, 2, 9,  7'b0010011);   // slti x9,x1,-1
    rom[10] = enc_i(32'hF0, 2, 7, 10, 7'b0010011);  // andi x10,x2,0xf0
    rom[11] = enc_r(0,     2, 1, 6, 13);            // or   x13,x1,x2
    rom[12] = enc_r(0,     2, 1, 4, 14);            // xor  x14,x1,x2
    rom[13] = enc_i(32'h100, 1, 6, 15, 7'b0010011); // ori  x15,x1,0x100
    rom[14] = enc_i(-1,    1, 4, 16, 7'b0010011);   // xori x16,x1,-1
    rom[15] = enc_r(0,     2, 1, 7, 17);            // and  x17,x1,x2
    rom[16] = enc_b(8,     0, 1, 0);                // beq  x1,x0,+8 (not taken)
    rom[17] = 32'h0000_0000;                        // illegal word
    rom[18] = enc_s(0,     1, 0);                   // sw   x1,0(x0)
    rom[19] = enc_j(16,    11);                     // jal  x11,+16
    rom[21] = 32'hDEAD_BEEF;                        // load data at byte 84
    rom[23] = enc_i(-1,    1, 0, 1,  7'b0010011);   // addi x1,x1,-1
    rom[24] = enc_i(1,     12, 0, 12, 7'b0010011);  // addi x12,x12,1
    rom[25] = enc_b(-8,    0, 1, 1);                // bne  x1,x0,-8
    rom[26] = enc_j(0,     0);                      // jal  x0,0

    vecs.push_back(mk(0,   0, 0,  1,  32'd5));
    vecs.push_back(mk(4,   0, 0,  2,  32'hFFFF_FFFD));
    vecs.push_back(mk(8,   0, 0,  3,  32'd2));
    vecs.push_back(mk(12,  0, 0,  4,  32'h1234_5000));
    vecs.push_back(mk(16,  0, 0,  0,  32'd0));
    vecs.push_back(mk(20,  1, 84, 5,  32'hDEAD_BEEF));
    vecs.push_back(mk(24,  1, 84, 6,  32'hDEAD_BEEF));
    vecs.push_back(mk(28,  0, 0,  7,  32'hFFFF_FFF8));
    vecs.push_back(mk(32,  0, 0,  8,  32'd1));
    vecs.push_back(mk(36,  0, 0,  9,  32'd0));
    vecs.push_back(mk(40,  0, 0,  10, 32'h0000_00F0));
    vecs.push_back(mk(44,  0, 0,  13, 32'hFFFF_FFFD));
    vecs.push_back(mk(48,  0, 0,  14, 32'hFFFF_FFF8));
    vecs.push_back(mk(52,  0, 0,  15, 32'h0000_0105));
    vecs.push_back(mk(56,  0, 0,  16, 32'hFFFF_FFFA));
    vecs.push_back(mk(60,  0, 0,  17, 32'd5));
    vecs.push_back(mk(64,  0, 0,  0,  32'd0));
    vecs.push_back(mk(68,  0, 0,  0,  32'd0));
    vecs.push_back(mk(72,  0, 0,  0,  32'd0));
    vecs.push_back(mk(76,  0, 0,  11, 32'd80));
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(mk(92,  0, 0, 1,  32'(5 - k)));
      vecs.push_back(mk(96,  0, 0, 12, 32'(k)));
      vecs.push_back(mk(100, 0, 0, 0,  32'd0));
    end
    vecs.push_back(mk(104, 0, 0, 0, 32'd0));
    vecs.push_back(mk(104, 0, 0, 0, 32'd0));

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_addr", addr_o, 32'd0);
    check("reset_we", {31'b0, we_o}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset from the self-loop, then abort a load while it is in MEM.
    reset = 1'b1;
    #1;
    check("reset_from_loop_addr", addr_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    check("lw_fetch_addr", addr_o, 32'd20);
    @(negedge clk);
    check("lw_exec_addr", addr_o, 32'd20);
    @(negedge clk);
    check("lw_mem_addr", addr_o, 32'd84);
    reset = 1'b1;
    #1;
    check("reset_in_mem_addr", addr_o, 32'd0);
    check("reset_in_mem_x1", reg_val(5'd1), 32'd0);
    check("reset_in_mem_x5", reg_val(5'd5), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);
    check("after_abort_x5", reg_val(5'd5), 32'd0);
    check("we_never_high", we_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
